instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, word address fetched first after reset.
REQ-002 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-003 Parameter DATA_W, default 32, instruction width.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_address  output  ADDR_W  address presented to the synchronous instruction memory.
REQ-007 imem_q  input  DATA_W  memory read data, valid one cycle after the address is sampled.
REQ-008 redirect  input  1  branch/jump request; priority over all other activity.
REQ-009 redirect_target  input  ADDR_W  new fetch address, sampled when redirect=1.
REQ-010 instr  output  DATA_W  instruction at buffer head.
REQ-011 instr_pc  output  ADDR_W  word address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-013 instr_ready  input  1  consumer accepts; transfer occurs when instr_valid & instr_ready.
REQ-014 fetch_count  output  16  number of completed transfers, wraps 16'hFFFF -> 16'h0000.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FLUSH; IDLE SHALL last exactly one cycle after reset release, then go to RUN.
REQ-016 imem_address SHALL always equal fetch_pc, a registered word pointer.
REQ-017 An issue SHALL occur in RUN or FLUSH when count + inflight - (instr_valid & instr_ready) < 2, where count is buffer occupancy (0..2) and inflight is a 1-bit flag for an issued, unreturned read.
REQ-018 On issue, inflight SHALL be set and fetch_pc SHALL increment by 1 modulo 2^ADDR_W (8'hFF -> 8'h00); otherwise fetch_pc SHALL hold.
REQ-019 In RUN, the cycle after an issue, {fetch_pc of that issue, imem_q} SHALL be written to a 2-entry FIFO; instr_valid SHALL rise the following cycle (issue-to-valid latency 2 cycles).
REQ-020 Simultaneous FIFO write and transfer SHALL leave count unchanged; a full FIFO SHALL never be written (guaranteed by REQ-017).
REQ-021 instr, instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-022 On redirect=1 in any non-IDLE state: a same-cycle transfer SHALL complete and be counted, then the FIFO SHALL be emptied, fetch_pc SHALL load redirect_target, state SHALL go to FLUSH.
REQ-023 In FLUSH, the arriving imem_q SHALL be discarded, redirect_target SHALL be issued, state SHALL go to RUN; redirect during FLUSH SHALL restart FLUSH with the new target.
REQ-024 redirect-to-instr_valid latency SHALL be 3 cycles, with instr_pc = redirect_target.
REQ-025 redirect in IDLE SHALL be ignored.

Reset
REQ-026 During reset: state=IDLE, fetch_pc=RESET_PC, inflight=0, count=0, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, imem_address=RESET_PC.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions immediately, without waiting for a clock edge.

Structure
REQ-028 FSM state encodings and RESET_PC default SHALL live in the shared package fetch_pkg.
REQ-029 The 2-entry buffer SHALL be a sub-module fetch_fifo2 (push, pop, flush, count, head data).
REQ-030 Datapath width SHALL come only from ADDR_W/DATA_W; no hard-coded 8/32 in logic.

Verification
REQ-031 Reset, InstructionMemory attached, instr_ready=1 -> cycle 3 after release: instr=32'h20010003, instr_pc=0; cycle 4: 32'h20020000, pc=1; one instruction per cycle thereafter.
REQ-032 instr_ready=0 for 5 cycles after first valid -> instr held at pc=0, count=2, no issue, imem_address=2; release -> pc 0,1,2 delivered on consecutive cycles.
REQ-033 redirect=1, target=8'h02 while pc=3 valid and accepted -> fetch_count incremented, buffer emptied, 3 cycles later instr=32'h20420001, pc=2.
REQ-034 Back-to-back redirects to 8'h05 then 8'h0A -> only 32'h0800000A at pc=10 delivered; nothing from 5.
REQ-035 RESET_PC=8'hFE, instr_ready=1 -> instr_pc sequence FE, FF, 00, 01.
REQ-036 Reset pulsed between clock edges while count=2 -> instr_valid=0 and fetch_pc=RESET_PC before next edge; fetch restarts normally.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and the
// default reset fetch address.
package fetch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [7:0] FETCH_RESET_PC = 8'h00;
endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry instruction buffer. The head entry is read straight from storage,
// so the outputs stay stable while nothing is popped.
module fetch_fifo2 #(
  parameter int W = 40
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetch from a synchronous memory into a 2-entry
// buffer, with redirect (branch) handling through a one-cycle FLUSH state.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [DATA_W-1:0] imem_q,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       fetch_count
);
  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              inflight_q, inflight_d;
  logic [15:0]       fetch_count_q, fetch_count_d;

  logic [1:0]               fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic                     xfer, redir_act, issue, push;
  logic [2:0]               occ;

  assign xfer      = instr_valid & instr_ready;
  assign redir_act = redirect & (state_q != ST_IDLE);
  // Occupancy after this cycle's transfer; never underflows since xfer needs count>0.
  assign occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, xfer};
  assign issue     = (state_q == ST_RUN || state_q == ST_FLUSH) && !redirect && (occ < 3'd2);
  assign push      = (state_q == ST_RUN) && inflight_q && !redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pend_pc_d     = pend_pc_q;
    inflight_d    = inflight_q;
    fetch_count_d = fetch_count_q + {15'd0, xfer};
    if (redir_act) begin
      fetch_pc_d = redirect_target;
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      pend_pc_d  = fetch_pc_q;
      inflight_d = 1'b1;
    end else if (push) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_q <= ST_RUN;
        ST_RUN:   if (redirect) state_q <= ST_FLUSH;
        ST_FLUSH: state_q <= redirect ? ST_FLUSH : ST_RUN;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      pend_pc_q     <= '0;
      inflight_q    <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pend_pc_q     <= pend_pc_d;
      inflight_q    <= inflight_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_fifo2 #(.W(ADDR_W + DATA_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (xfer),
    .flush_i (redir_act),
    .din_i   ({pend_pc_q, imem_q}),
    .dout_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign imem_address = fetch_pc_q;
  assign instr        = fifo_head[DATA_W-1:0];
  assign instr_pc     = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign instr_valid  = (fifo_count != 2'd0);
  assign fetch_count  = fetch_count_q;
endmodule
